adder_cpa4: RTL and testbench

- Registered 4-bit carry-propagate (ripple-carry) adder: s = a + b, modulo 2^WIDTH, plus a carry-out flag.
- Used as a small arithmetic leaf in datapaths.
- Inputs are sampled on a valid strobe; the result and carry are presented one clock later with a matching valid.
- The adder core is a chain of full-adder cells, so the carry visibly ripples from bit 0 to bit WIDTH-1.

---
 rtl/adder_pkg.sv | 8 +
 rtl/full_adder_cell.sv | 16 +
 rtl/adder_cpa4.sv | 47 ++++
 tb/tb_adder_cpa4.sv | 102 ++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and defaults for the registered ripple-carry adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; chained by adder_cpa4 to form the ripple-carry core.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop;

  assign prop = a ^ b;
  assign sum  = prop ^ cin;
  assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/adder_cpa4.sv
// Registered WIDTH-bit ripple-carry adder with carry-out and a 1-cycle valid.
module adder_cpa4
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  // Result registers load only on in_valid, so X operands on idle cycles never reach s/cout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_c;
        cout <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_adder_cpa4.sv
// Directed and exhaustive checks for adder_cpa4 with a 1-cycle result latency.
module tb_adder_cpa4;
  import adder_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  word_t a;
  word_t b;
  logic  out_valid;
  word_t s;
  logic  cout;

  int n_pass  = 0;
  int n_total = 0;

  adder_cpa4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic v, input word_t ia, input word_t ib);
    rst_n    = r;
    in_valid = v;
    a        = ia;
    b        = ib;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic ev, input word_t es, input logic ec);
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ev});
    chk({tag, ".s"}, {4'd0, s}, {4'd0, es});
    chk({tag, ".cout"}, {7'd0, cout}, {7'd0, ec});
  endtask

  // operand A, operand B, expected sum, expected carry
  word_t dir_a [8] = '{4'd0, 4'd4, 4'd8,  4'd1, 4'd4,  4'd15, 4'd15, 4'd7};
  word_t dir_b [8] = '{4'd0, 4'd2, 4'd2,  4'd1, 4'd8,  4'd1,  4'd15, 4'd9};
  word_t dir_s [8] = '{4'd0, 4'd6, 4'd10, 4'd2, 4'd12, 4'd0,  4'd14, 4'd0};
  logic  dir_c [8] = '{1'b0, 1'b0, 1'b0,  1'b0, 1'b0,  1'b1,  1'b1,  1'b1};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    cyc(1'b0, 1'b1, 4'h5, 4'h3);
    chk_out("reset0", 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h5, 4'h3);
    chk_out("reset1", 1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, dir_a[i], dir_b[i]);
      chk_out($sformatf("dir%0d", i), 1'b1, dir_s[i], dir_c[i]);
    end

    cyc(1'b1, 1'b1, 4'd3, 4'd4);
    chk_out("hold_load", 1'b1, 4'd7, 1'b0);
    cyc(1'b1, 1'b0, 4'd15, 4'd15);
    chk_out("hold_idle", 1'b0, 4'd7, 1'b0);
    cyc(1'b1, 1'b0, 4'bxxxx, 4'bxxxx);
    chk_out("hold_x", 1'b0, 4'd7, 1'b0);

    cyc(1'b1, 1'b1, 4'd15, 4'd15);
    chk_out("pre_rst", 1'b1, 4'd14, 1'b1);
    cyc(1'b0, 1'b1, 4'd9, 4'd9);
    chk_out("mid_rst", 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b1, 4'd2, 4'd3);
    chk_out("post_rst", 1'b1, 4'd5, 1'b0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        cyc(1'b1, 1'b1, word_t'(i), word_t'(j));
        chk($sformatf("exh_%0d_%0d.sum", i, j), {3'd0, cout, s}, 8'(i + j));
        chk($sformatf("exh_%0d_%0d.valid", i, j), {7'd0, out_valid}, 8'd1);
      end
    end

    cyc(1'b1, 1'b0, 4'd0, 4'd0);
    chk_out("final_idle", 1'b0, 4'd14, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
